// File: rtl/date_counter.sv
// Calendar day/month/year counter for 2000..2099 with a validated parallel load.
// DD/MM/YY and the wrap/error pulses are all registered; leap is decoded from the registered YY.
module date_counter #(
  parameter logic [4:0] RESET_DD = 5'd1,
  parameter logic [3:0] RESET_MM = 4'd1,
  parameter logic [6:0] RESET_YY = 7'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       day_tick,
  input  logic       load,
  input  logic [4:0] load_dd,
  input  logic [3:0] load_mm,
  input  logic [6:0] load_yy,
  output logic [4:0] DD,
  output logic [3:0] MM,
  output logic [6:0] YY,
  output logic       leap,
  output logic       month_wrap,
  output logic       year_wrap,
  output logic       load_err
);

  logic [4:0] dd_q, dd_d;
  logic [3:0] mm_q, mm_d;
  logic [6:0] yy_q, yy_d;
  logic       month_wrap_q, month_wrap_d;
  logic       year_wrap_q, year_wrap_d;
  logic       load_err_q, load_err_d;

  logic [4:0] cur_mlen;
  logic [4:0] load_mlen;
  logic       state_ok;
  logic       load_ok;

  function automatic logic [4:0] mlen(input logic [3:0] mm, input logic [6:0] yy);
    logic [4:0] len;
    case (mm)
      4'd2:                     len = (yy[1:0] == 2'b00) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:  len = 5'd30;
      default:                  len = 5'd31;
    endcase
    return len;
  endfunction

  assign cur_mlen  = mlen(mm_q, yy_q);
  assign load_mlen = mlen(load_mm, load_yy);

  // A corrupted register set (e.g. after an upset) is caught here and reloaded on the next tick.
  assign state_ok = (mm_q >= 4'd1) && (mm_q <= 4'd12) && (yy_q <= 7'd99) &&
                    (dd_q >= 5'd1) && (dd_q <= cur_mlen);

  assign load_ok  = (load_mm >= 4'd1) && (load_mm <= 4'd12) && (load_yy <= 7'd99) &&
                    (load_dd >= 5'd1) && (load_dd <= load_mlen);

  always_comb begin
    dd_d         = dd_q;
    mm_d         = mm_q;
    yy_d         = yy_q;
    month_wrap_d = 1'b0;
    year_wrap_d  = 1'b0;
    load_err_d   = 1'b0;
    // Load has priority; a coincident tick is dropped even if the load is rejected.
    if (load) begin
      if (load_ok) begin
        dd_d = load_dd;
        mm_d = load_mm;
        yy_d = load_yy;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (day_tick) begin
      if (!state_ok) begin
        dd_d = RESET_DD;
        mm_d = RESET_MM;
        yy_d = RESET_YY;
      end else if (dd_q < cur_mlen) begin
        dd_d = dd_q + 5'd1;
      end else if (mm_q < 4'd12) begin
        dd_d         = 5'd1;
        mm_d         = mm_q + 4'd1;
        month_wrap_d = 1'b1;
      end else begin
        dd_d         = 5'd1;
        mm_d         = 4'd1;
        yy_d         = (yy_q == 7'd99) ? 7'd0 : yy_q + 7'd1;
        month_wrap_d = 1'b1;
        year_wrap_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dd_q         <= RESET_DD;
      mm_q         <= RESET_MM;
      yy_q         <= RESET_YY;
      month_wrap_q <= 1'b0;
      year_wrap_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      dd_q         <= dd_d;
      mm_q         <= mm_d;
      yy_q         <= yy_d;
      month_wrap_q <= month_wrap_d;
      year_wrap_q  <= year_wrap_d;
      load_err_q   <= load_err_d;
    end
  end

  assign DD         = dd_q;
  assign MM         = mm_q;
  assign YY         = yy_q;
  assign leap       = (yy_q[1:0] == 2'b00);
  assign month_wrap = month_wrap_q;
  assign year_wrap  = year_wrap_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_date_counter.sv
// Directed bench for date_counter: table of load/tick vectors with hand-computed dates,
// plus a full-year tick run and an asynchronous reset sequence.
module tb_date_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       day_tick;
  logic       load;
  logic [4:0] load_dd;
  logic [3:0] load_mm;
  logic [6:0] load_yy;
  logic [4:0] DD;
  logic [3:0] MM;
  logic [6:0] YY;
  logic       leap;
  logic       month_wrap;
  logic       year_wrap;
  logic       load_err;

  int n_checks = 0;
  int n_fail   = 0;

  date_counter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .day_tick   (day_tick),
    .load       (load),
    .load_dd    (load_dd),
    .load_mm    (load_mm),
    .load_yy    (load_yy),
    .DD         (DD),
    .MM         (MM),
    .YY         (YY),
    .leap       (leap),
    .month_wrap (month_wrap),
    .year_wrap  (year_wrap),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    bit    tick;
    bit    ld;
    int    ldd, lmm, lyy;
    int    edd, emm, eyy;
    bit    emw, eyw, ele;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, bit tick, bit ld, int ldd, int lmm, int lyy,
                              int edd, int emm, int eyy, bit emw, bit eyw, bit ele);
    vec_t v;
    v.name = name; v.tick = tick; v.ld = ld;
    v.ldd = ldd; v.lmm = lmm; v.lyy = lyy;
    v.edd = edd; v.emm = emm; v.eyy = eyy;
    v.emw = emw; v.eyw = eyw; v.ele = ele;
    return v;
  endfunction

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_date(string name, int edd, int emm, int eyy, bit emw, bit eyw, bit ele);
    check({name, ".DD"}, int'(DD), edd);
    check({name, ".MM"}, int'(MM), emm);
    check({name, ".YY"}, int'(YY), eyy);
    check({name, ".leap"}, int'(leap), ((eyy % 4) == 0) ? 1 : 0);
    check({name, ".month_wrap"}, int'(month_wrap), int'(emw));
    check({name, ".year_wrap"}, int'(year_wrap), int'(eyw));
    check({name, ".load_err"}, int'(load_err), int'(ele));
  endtask

  task automatic apply(vec_t v);
    @(negedge clk);
    day_tick = v.tick;
    load     = v.ld;
    load_dd  = 5'(v.ldd);
    load_mm  = 4'(v.lmm);
    load_yy  = 7'(v.lyy);
    @(posedge clk);
    #1;
    day_tick = 1'b0;
    load     = 1'b0;
    check_date(v.name, v.edd, v.emm, v.eyy, v.emw, v.eyw, v.ele);
  endtask

  int mw_cnt;
  int yw_cnt;

  initial begin
    rst_n = 1'b0; day_tick = 1'b0; load = 1'b0;
    load_dd = '0; load_mm = '0; load_yy = '0;

    repeat (2) @(negedge clk);
    check_date("reset", 1, 1, 0, 0, 0, 0);
    rst_n = 1'b1;

    //                name        tk ld  ldd lmm lyy  edd emm eyy mw yw le
    vecs.push_back(mk("ld31jan23", 0, 1, 31,  1, 23,  31,  1, 23, 0, 0, 0));
    vecs.push_back(mk("tk_feb1",   1, 0,  0,  0,  0,   1,  2, 23, 1, 0, 0));
    vecs.push_back(mk("idle_mw0",  0, 0,  0,  0,  0,   1,  2, 23, 0, 0, 0));
    vecs.push_back(mk("ld28feb23", 0, 1, 28,  2, 23,  28,  2, 23, 0, 0, 0));
    vecs.push_back(mk("tk_mar23",  1, 0,  0,  0,  0,   1,  3, 23, 1, 0, 0));
    vecs.push_back(mk("ld28feb24", 0, 1, 28,  2, 24,  28,  2, 24, 0, 0, 0));
    vecs.push_back(mk("tk_29feb",  1, 0,  0,  0,  0,  29,  2, 24, 0, 0, 0));
    vecs.push_back(mk("tk_mar24",  1, 0,  0,  0,  0,   1,  3, 24, 1, 0, 0));
    vecs.push_back(mk("ld30jun11", 0, 1, 30,  6, 11,  30,  6, 11, 0, 0, 0));
    vecs.push_back(mk("tk_jul11",  1, 0,  0,  0,  0,   1,  7, 11, 1, 0, 0));
    vecs.push_back(mk("ld15dec23", 0, 1, 15, 12, 23,  15, 12, 23, 0, 0, 0));
    vecs.push_back(mk("tk_16dec",  1, 0,  0,  0,  0,  16, 12, 23, 0, 0, 0));
    vecs.push_back(mk("ld31dec99", 0, 1, 31, 12, 99,  31, 12, 99, 0, 0, 0));
    vecs.push_back(mk("tk_y2k",    1, 0,  0,  0,  0,   1,  1,  0, 1, 1, 0));
    vecs.push_back(mk("idle_yw0",  0, 0,  0,  0,  0,   1,  1,  0, 0, 0, 0));
    vecs.push_back(mk("bad29f23",  0, 1, 29,  2, 23,   1,  1,  0, 0, 0, 1));
    vecs.push_back(mk("idle_le0",  0, 0,  0,  0,  0,   1,  1,  0, 0, 0, 0));
    vecs.push_back(mk("bad31apr",  0, 1, 31,  4, 10,   1,  1,  0, 0, 0, 1));
    vecs.push_back(mk("bad0may",   0, 1,  0,  5, 10,   1,  1,  0, 0, 0, 1));
    vecs.push_back(mk("bad13mon",  0, 1, 15, 13, 10,   1,  1,  0, 0, 0, 1));
    vecs.push_back(mk("bad0mon",   0, 1, 10,  0, 10,   1,  1,  0, 0, 0, 1));
    vecs.push_back(mk("bady100",   0, 1, 15,  6,100,   1,  1,  0, 0, 0, 1));
    vecs.push_back(mk("ok29f00",   0, 1, 29,  2,  0,  29,  2,  0, 0, 0, 0));
    vecs.push_back(mk("ld30apr10", 0, 1, 30,  4, 10,  30,  4, 10, 0, 0, 0));
    vecs.push_back(mk("ldtk5jul",  1, 1,  5,  7, 11,   5,  7, 11, 0, 0, 0));
    vecs.push_back(mk("badldtk",   1, 1, 31,  6, 11,   5,  7, 11, 0, 0, 1));
    vecs.push_back(mk("tk_6jul",   1, 0,  0,  0,  0,   6,  7, 11, 0, 0, 0));

    foreach (vecs[i]) apply(vecs[i]);

    // Full non-leap year of back-to-back ticks
    apply(mk("ld1jan23", 0, 1, 1, 1, 23, 1, 1, 23, 0, 0, 0));
    mw_cnt = 0;
    yw_cnt = 0;
    @(negedge clk);
    day_tick = 1'b1;
    for (int i = 0; i < 365; i++) begin
      @(posedge clk);
      #1;
      if (month_wrap) mw_cnt++;
      if (year_wrap)  yw_cnt++;
    end
    day_tick = 1'b0;
    check("year.DD", int'(DD), 1);
    check("year.MM", int'(MM), 1);
    check("year.YY", int'(YY), 24);
    check("year.month_wraps", mw_cnt, 12);
    check("year.year_wraps", yw_cnt, 1);

    // Async reset while a wrap pulse is high, then first tick right after release
    apply(mk("ld27jan23", 0, 1, 27, 1, 23, 27, 1, 23, 0, 0, 0));
    apply(mk("t1", 1, 0, 0, 0, 0, 28, 1, 23, 0, 0, 0));
    apply(mk("t2", 1, 0, 0, 0, 0, 29, 1, 23, 0, 0, 0));
    apply(mk("t3", 1, 0, 0, 0, 0, 30, 1, 23, 0, 0, 0));
    apply(mk("t4", 1, 0, 0, 0, 0, 31, 1, 23, 0, 0, 0));
    apply(mk("t5", 1, 0, 0, 0, 0,  1, 2, 23, 1, 0, 0));
    #1;
    rst_n = 1'b0;
    #1;
    check_date("async_rst", 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    rst_n    = 1'b1;
    day_tick = 1'b1;
    @(posedge clk);
    #1;
    day_tick = 1'b0;
    check_date("first_tick", 2, 1, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
